// File: rtl/mem_write_fsm_if.sv
// Sensor-to-BRAM write handshake: per-sensor ready levels in, write strobe,
// selected sensor index and frame-complete pulse out.
interface mem_write_fsm_if #(
  parameter int NUM_SENSORS = 8
);
  logic [NUM_SENSORS-1:0] ToF_dr;
  logic                   wea;
  logic [2:0]             ToF_Index;
  logic                   all_data_written;

  modport slave (
    input  ToF_dr,
    output wea,
    output ToF_Index,
    output all_data_written
  );

  modport master (
    output ToF_dr,
    input  wea,
    input  ToF_Index,
    input  all_data_written
  );
endinterface

// File: rtl/mem_write_fsm.sv
// Round-robin arbiter that writes one word per ready assertion from each ToF
// sensor into BRAM and pulses all_data_written once every sensor has a frame.
module mem_write_fsm #(
  parameter int NUM_SENSORS     = 8,
  parameter int WORDS_PER_FRAME = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_write_fsm_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   wea_q, wea_nxt;
  logic                   adw_q, adw_nxt;
  logic [2:0]             idx_q, idx_nxt;
  logic [2:0]             ptr, ptr_nxt;
  logic [NUM_SENSORS-1:0] done_mask, mask_nxt;
  logic [6:0]             cnt     [NUM_SENSORS];
  logic [6:0]             cnt_nxt [NUM_SENSORS];

  logic                   found;
  logic [2:0]             sel;
  logic [3:0]             sum;
  logic [2:0]             cand;

  assign bus.wea              = wea_q;
  assign bus.ToF_Index        = idx_q;
  assign bus.all_data_written = adw_q;

  // First ready, not-yet-complete sensor at or after ptr, wrapping modulo NUM_SENSORS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(NUM_SENSORS))
        cand = 3'(sum - 4'(NUM_SENSORS));
      else
        cand = sum[2:0];
      if (!found && bus.ToF_dr[cand] && !done_mask[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wea_nxt   = 1'b0;
    adw_nxt   = 1'b0;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr;
    mask_nxt  = done_mask;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nxt   = sel;
          wea_nxt   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = HOLD;
        ptr_nxt   = (idx_q == 3'(NUM_SENSORS - 1)) ? 3'd0 : idx_q + 3'd1;
        if (cnt[idx_q] == 7'(WORDS_PER_FRAME - 1)) begin
          cnt_nxt[idx_q]  = '0;
          mask_nxt[idx_q] = 1'b1;
        end else begin
          cnt_nxt[idx_q] = cnt[idx_q] + 7'd1;
        end
      end
      HOLD: begin
        if (!bus.ToF_dr[idx_q]) begin
          if (&done_mask) begin
            state_nxt = DONE;
            adw_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        mask_nxt  = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wea_q     <= 1'b0;
      adw_q     <= 1'b0;
      idx_q     <= '0;
      ptr       <= '0;
      done_mask <= '0;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      wea_q     <= wea_nxt;
      adw_q     <= adw_nxt;
      idx_q     <= idx_nxt;
      ptr       <= ptr_nxt;
      done_mask <= mask_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_write_fsm.sv
// Directed bench for mem_write_fsm: single/held/frame/reset scenarios with
// hand-computed write and frame-complete counts.
module tb_mem_write_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   wea_cnt;
  int   adw_cnt;
  int   base_wea;
  int   base_adw;
  logic [2:0] last_idx;

  mem_write_fsm_if #(.NUM_SENSORS(8)) bus ();

  mem_write_fsm #(
    .NUM_SENSORS     (8),
    .WORDS_PER_FRAME (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle tallies of write strobes and frame-complete pulses.
  always @(posedge clk) begin
    #1;
    if (bus.wea === 1'b1) begin
      wea_cnt  = wea_cnt + 1;
      last_idx = bus.ToF_Index;
    end
    if (bus.all_data_written === 1'b1) adw_cnt = adw_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ready assertion: high for two cycles, low for two.
  task automatic pulse(input logic [7:0] mask);
    bus.ToF_dr = mask;
    cyc(2);
    bus.ToF_dr = 8'h00;
    cyc(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    wea_cnt    = 0;
    adw_cnt    = 0;
    last_idx   = '0;
    bus.ToF_dr = 8'h00;
    reset      = 1'b0;
    cyc(3);
    check("rst_wea", 32'(bus.wea), 32'd0);
    check("rst_idx", 32'(bus.ToF_Index), 32'd0);
    check("rst_adw", 32'(bus.all_data_written), 32'd0);
    reset = 1'b1;
    cyc(2);

    // Single pulse on sensor 2
    base_wea = wea_cnt;
    pulse(8'h04);
    check("single_wea", 32'(wea_cnt - base_wea), 32'd1);
    check("single_idx", 32'(last_idx), 32'd2);
    check("single_adw", 32'(adw_cnt), 32'd0);

    // Sensors 0 and 7 held high from ptr=0
    do_reset();
    base_wea = wea_cnt;
    bus.ToF_dr = 8'h81;
    cyc(6);
    check("held81_first_cnt", 32'(wea_cnt - base_wea), 32'd1);
    check("held81_first_idx", 32'(last_idx), 32'd0);
    bus.ToF_dr = 8'h80;
    cyc(6);
    check("held81_second_cnt", 32'(wea_cnt - base_wea), 32'd2);
    check("held81_second_idx", 32'(last_idx), 32'd7);
    bus.ToF_dr = 8'h00;
    cyc(3);

    // Sensor 1 held for 10 cycles
    base_wea = wea_cnt;
    bus.ToF_dr = 8'h02;
    cyc(10);
    bus.ToF_dr = 8'h00;
    cyc(3);
    check("held1_wea", 32'(wea_cnt - base_wea), 32'd1);

    // Sensor 3 completes a frame; extra pulses are ignored
    do_reset();
    base_wea = wea_cnt;
    base_adw = adw_cnt;
    for (int i = 0; i < 64; i++) pulse(8'h08);
    check("s3_frame_wea", 32'(wea_cnt - base_wea), 32'd64);
    base_wea = wea_cnt;
    for (int i = 0; i < 3; i++) pulse(8'h08);
    check("s3_masked_wea", 32'(wea_cnt - base_wea), 32'd0);
    check("s3_no_adw", 32'(adw_cnt - base_adw), 32'd0);

    // All eight sensors, interleaved
    do_reset();
    base_wea = wea_cnt;
    base_adw = adw_cnt;
    for (int w = 0; w < 64; w++)
      for (int s = 0; s < 8; s++) begin
        logic [7:0] m;
        m = 8'h01 << s;
        pulse(m);
      end
    check("all_frame_wea", 32'(wea_cnt - base_wea), 32'd512);
    check("all_frame_adw", 32'(adw_cnt - base_adw), 32'd1);
    base_wea = wea_cnt;
    pulse(8'h08);
    check("mask_cleared_wea", 32'(wea_cnt - base_wea), 32'd1);
    check("adw_single_cycle", 32'(adw_cnt - base_adw), 32'd1);

    // Reset mid-frame on sensor 5 discards the partial count
    do_reset();
    for (int i = 0; i < 30; i++) pulse(8'h20);
    bus.ToF_dr = 8'h20;
    @(posedge clk);
    #2;
    check("mid_wea_high", 32'(bus.wea), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_wea", 32'(bus.wea), 32'd0);
    check("mid_rst_idx", 32'(bus.ToF_Index), 32'd0);
    bus.ToF_dr = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    base_wea = wea_cnt;
    for (int i = 0; i < 64; i++) pulse(8'h20);
    check("s5_refill_wea", 32'(wea_cnt - base_wea), 32'd64);
    base_wea = wea_cnt;
    pulse(8'h20);
    check("s5_masked_wea", 32'(wea_cnt - base_wea), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_fsm.md
MEM_WRITE_FSM -- requirements
Module: mem_write_fsm

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 8, giving the number of ToF sensor channels.
REQ-002 The block SHALL have parameter WORDS_PER_FRAME, default 64, giving the words per sensor per frame.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port ToF_dr, input, NUM_SENSORS bits: per-sensor data-ready level; bit i high means sensor i presents one word.
REQ-007 Port wea, output, 1 bit: BRAM write enable; the BRAM address is formed outside the block as {ToF_Index, word address}.
REQ-008 Port ToF_Index, output, 3 bits: index of the sensor being serviced; it steers the data/address mux outside the block.
REQ-009 Port all_data_written, output, 1 bit: one-cycle pulse when every sensor has completed a frame.

Function
REQ-010 The block SHALL implement the states IDLE, WRITE, HOLD and DONE.
REQ-011 The block SHALL keep a 3-bit round-robin pointer ptr, a NUM_SENSORS-bit done_mask, and a 7-bit word counter for each sensor.
REQ-012 In IDLE, the block SHALL select the first sensor i, searching from ptr upward modulo NUM_SENSORS, for which ToF_dr[i]=1 and done_mask[i]=0.
REQ-013 On a selection in IDLE, the block SHALL register ToF_Index<=i and go to WRITE; if there is no candidate it SHALL stay in IDLE with wea=0.
REQ-014 Ready bits of sensors whose done_mask bit is set SHALL be ignored.
REQ-015 WRITE SHALL last exactly one cycle, with wea=1; wea SHALL be 0 in every other state.
REQ-016 Leaving WRITE, the block SHALL increment cnt[i] and set ptr<=i+1 modulo NUM_SENSORS.
REQ-017 If cnt[i] reaches WORDS_PER_FRAME, the block SHALL set done_mask[i]=1 and clear cnt[i] to 0 (wrap).
REQ-018 From WRITE the block SHALL go to HOLD.
REQ-019 In HOLD, the block SHALL wait until ToF_dr[ToF_Index]=0, then leave HOLD; this gives exactly one write per ready assertion.
REQ-020 ToF_Index SHALL stay stable from WRITE through HOLD.
REQ-021 On leaving HOLD, the block SHALL go to DONE if done_mask is all ones, and to IDLE otherwise.
REQ-022 DONE SHALL last one cycle, with all_data_written=1; it SHALL clear done_mask, leave ptr unchanged, and return to IDLE.
REQ-023 When several ready bits are asserted together, one sensor SHALL be serviced per WRITE/HOLD pass, in round-robin order from ptr.
REQ-024 A ready level that stays high SHALL NOT cause a second write until it has dropped and risen again.
REQ-025 The minimum spacing between writes SHALL be 3 cycles (IDLE, WRITE, HOLD), with HOLD left as soon as ready is low.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset=0 (asynchronously), the block SHALL hold state=IDLE, wea=0, ToF_Index=0, all_data_written=0, ptr=0, done_mask=0 and all counters=0.
REQ-028 Reset asserted mid-frame SHALL discard all partial counts.
REQ-029 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-030 Reset, then a single pulse on ToF_dr=8'h04 -> one cycle of wea=1 with ToF_Index=2; cnt[2]=1; no all_data_written.
REQ-031 ToF_dr=8'h81 held high, with ptr=0 -> sensor 0 written first; after bit 0 is dropped, sensor 7 is written; 2 writes total.
REQ-032 Sensor 3 given 64 pulses -> 64 wea pulses; then further ToF_dr[3] pulses produce no wea until the frame completes.
REQ-033 All 8 sensors given 64 pulses each, interleaved -> 512 wea pulses, then all_data_written high for exactly 1 cycle, and done_mask cleared.
REQ-034 Reset driven low after sensor 5 has delivered 30 words -> wea=0 immediately; afterwards 64 new words are again needed for sensor 5.
REQ-035 ToF_dr[1] held high for 10 cycles -> exactly 1 wea pulse.
